sprite_fetch_sequencer: RTL
===========================

SPRITE_FETCH_SEQUENCER -- requirements
Module: sprite_fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 26: width of the RAM word address and of all address arithmetic.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid/cmd_ready  input/output  1/1  command handshake; transfer when both are high on a clk edge.
REQ-005 cmd_is_sprite  input  1  1 = sprite rectangle walk, 0 = text character walk.
REQ-006 cmd_base  input  ADDR_W  layer base word address.
REQ-007 cmd_frame  input  8 (unsigned)  sprite frame number.
REQ-008 cmd_height, cmd_width  input  16/16 (unsigned)  sprite frame dimensions in pixels.
REQ-009 cmd_x0, cmd_y0  input  16/16 (signed)  top-left pixel of the walk inside the frame.
REQ-010 cmd_cols, cmd_rows  input  16/16 (unsigned)  walk size in pixels.
REQ-011 cmd_char_index, cmd_char_count  input  16/16 (unsigned)  first character and number of characters (text mode).
REQ-012 rd_valid/rd_ready  output/input  1/1  read-request handshake; a beat transfers when both are high.
REQ-013 rd_addr  output  ADDR_W  read word address; rd_last  output  1  marks the final walk position.
REQ-014 busy  output  1  high in any state except IDLE; done  output  1  one-cycle completion pulse.

Function
REQ-015 States SHALL be IDLE, SETUP, EMIT and DONE; cmd_ready SHALL be high only in IDLE.
REQ-016 IDLE->SETUP on command transfer; all cmd_* fields SHALL be latched, and later changes to cmd_* SHALL be ignored.
REQ-017 SETUP, 1 cycle, sprite: row_base = cmd_base + frame*height*width + y0*width; x = x0; row = 0.
REQ-018 SETUP, text: char = char_index.
REQ-019 SETUP->DONE when (sprite and (cols==0 or rows==0)) or (text and char_count==0); otherwise SETUP->EMIT.
REQ-020 The first rd_valid SHALL occur 2 cycles after the command-transfer edge.
REQ-021 EMIT, sprite: rd_addr = row_base + x.
REQ-022 EMIT, text: rd_addr = cmd_base + (char << 1).
REQ-023 A beat SHALL advance only on rd_valid&rd_ready, at up to one beat per cycle.
REQ-024 While rd_ready is low, rd_valid, rd_addr and rd_last SHALL hold stable.
REQ-025 Sprite advance: x += 1; after column cols-1, x = x0, row_base += width and row += 1.
REQ-026 Text advance: char += 1.
REQ-027 rd_last SHALL be high on the beat for the final walk position: column cols-1 of row rows-1, or character char_count-1.
REQ-028 EMIT->DONE after the final beat transfers; DONE lasts 1 cycle with done=1, then the block returns to IDLE.
REQ-029 All address arithmetic SHALL be modulo 2^ADDR_W, with signed operands sign-extended and unsigned operands zero-extended before use.
REQ-030 The block SHALL issue no duplicated beats and no skipped beats, except as specified in REQ-036.

Reset
REQ-031 On reset assertion, independent of clk, the state SHALL go to IDLE and rd_valid, rd_last, done and busy SHALL go to 0.
REQ-032 During reset, rd_addr SHALL be 0 and cmd_ready SHALL be 0.
REQ-033 cmd_ready SHALL be 1 in the first cycle after reset release.
REQ-034 A reset mid-walk SHALL abandon the command with no done pulse.

Configuration
REQ-035 Macro SPRITE_CLIP_EN.
REQ-036 Defined: a sprite position with x<0, x>=width, current y<0 or y>=height SHALL be skipped; a skipped position takes one cycle with rd_valid=0. rd_last is asserted only if the final position is emitted. done is always asserted.
REQ-037 Not defined: every position SHALL be emitted with no bounds checking.

Verification
REQ-038 Sprite: base=0x100, frame=2, h=4, w=8, x0=1, y0=1, cols=2, rows=2, rd_ready=1 -> rd_addr 0x149, 0x14A, 0x151, 0x152; rd_last on the 4th beat; done in the next cycle.
REQ-039 Text: base=0, char_index=5, count=3 -> rd_addr 0x00A, 0x00C, 0x00E; rd_last on 0x00E.
REQ-040 Backpressure: in REQ-038, rd_ready low for 3 cycles at beat 2 -> rd_addr held at 0x14A; the beat sequence is unchanged.
REQ-041 Sprite with rows=0 -> no rd_valid; done high 2 cycles after the accept edge.
REQ-042 Reset asserted after 2 beats of REQ-038 -> rd_valid and busy drop immediately; no done; a new command is accepted after release.
REQ-043 x0=-1, y0=0, w=8, h=4, cols=3, rows=1, base=0, frame=0.
REQ-044 For REQ-043, with SPRITE_CLIP_EN -> rd_addr 0x0, 0x1.
REQ-045 For REQ-043, without SPRITE_CLIP_EN -> rd_addr 0x3FFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/sprite_fetch_sequencer.sv
// Sprite/text read-address sequencer: walks a sprite rectangle or a run of text characters
// and issues one RAM word read per position. Optional SPRITE_CLIP_EN skips out-of-frame pixels.
module sprite_fetch_sequencer #(
  parameter int ADDR_W = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_is_sprite,
  input  logic [ADDR_W-1:0]    cmd_base,
  input  logic [7:0]           cmd_frame,
  input  logic [15:0]          cmd_height,
  input  logic [15:0]          cmd_width,
  input  logic signed [15:0]   cmd_x0,
  input  logic signed [15:0]   cmd_y0,
  input  logic [15:0]          cmd_cols,
  input  logic [15:0]          cmd_rows,
  input  logic [15:0]          cmd_char_index,
  input  logic [15:0]          cmd_char_count,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_last,
  output logic                 busy,
  output logic                 done
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // SETUP | one cycle: compute first row base / first character
  // EMIT  | issue one read per walk position
  // DONE  | one-cycle done pulse
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state;
  logic                is_sprite;
  logic [ADDR_W-1:0]   base;
  logic [7:0]          frame;
  logic [15:0]         height, width;
  logic signed [15:0]  x0, y0;
  logic [15:0]         cols, rows, char_index, char_count;

  logic [ADDR_W-1:0]   row_base;
  logic [ADDR_W-1:0]   chr;
  logic [15:0]         col, row, idx;

  logic [ADDR_W-1:0]   frame_off, y_off, addr_next;
  logic                walk_empty, last_pos, skip, step;

  assign frame_off  = ADDR_W'(frame) * ADDR_W'(height) * ADDR_W'(width);
  assign y_off      = ADDR_W'(y0) * ADDR_W'(width);
  assign walk_empty = is_sprite ? (cols == 16'd0 || rows == 16'd0) : (char_count == 16'd0);
  assign last_pos   = is_sprite ? (col == cols - 16'd1 && row == rows - 16'd1)
                                : (idx == char_count - 16'd1);
  assign addr_next  = is_sprite ? (row_base + ADDR_W'(x0) + ADDR_W'(col))
                                : (base + (chr << 1));

`ifdef SPRITE_CLIP_EN
  // Unsigned compare of the 18-bit position also rejects negative coordinates.
  logic [17:0] x_pos, y_pos;
  assign x_pos = {{2{x0[15]}}, x0} + {2'b00, col};
  assign y_pos = {{2{y0[15]}}, y0} + {2'b00, row};
  assign skip  = (state == EMIT) && is_sprite &&
                 (x_pos >= {2'b00, width} || y_pos >= {2'b00, height});
`else
  assign skip  = 1'b0;
`endif

  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rd_valid  = (state == EMIT) && !skip;
  assign rd_last   = rd_valid && last_pos;
  assign rd_addr   = (state == EMIT) ? addr_next : '0;
  assign step      = (state == EMIT) && ((rd_valid && rd_ready) || skip);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      is_sprite  <= 1'b0;
      base       <= '0;
      frame      <= '0;
      height     <= '0;
      width      <= '0;
      x0         <= '0;
      y0         <= '0;
      cols       <= '0;
      rows       <= '0;
      char_index <= '0;
      char_count <= '0;
      row_base   <= '0;
      chr        <= '0;
      col        <= '0;
      row        <= '0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            is_sprite  <= cmd_is_sprite;
            base       <= cmd_base;
            frame      <= cmd_frame;
            height     <= cmd_height;
            width      <= cmd_width;
            x0         <= cmd_x0;
            y0         <= cmd_y0;
            cols       <= cmd_cols;
            rows       <= cmd_rows;
            char_index <= cmd_char_index;
            char_count <= cmd_char_count;
            state      <= SETUP;
          end
        end
        SETUP: begin
          row_base <= base + frame_off + y_off;
          chr      <= ADDR_W'(char_index);
          col      <= '0;
          row      <= '0;
          idx      <= '0;
          state    <= walk_empty ? DONE : EMIT;
        end
        EMIT: begin
          if (step) begin
            if (last_pos) begin
              state <= DONE;
            end else if (is_sprite) begin
              if (col == cols - 16'd1) begin
                col      <= '0;
                row      <= row + 16'd1;
                row_base <= row_base + ADDR_W'(width);
              end else begin
                col <= col + 16'd1;
              end
            end else begin
              chr <= chr + ADDR_W'(1);
              idx <= idx + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
